des_key_sched_dec: RTL and testbench



---
 rtl/des_key_sched_dec.sv | 115 +++++++++++
 tb/tb_des_key_sched_dec.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_dec.sv
`default_nettype none
// ============================================================================
// Module  : des_key_sched_dec
// Brief   : Iterative DES decryption key schedule (K16 first, K1 last),
//           right-rotating C/D per round behind a ready/valid handshake.
// Revision: 1.0
// ============================================================================
module des_key_sched_dec #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [55:0]      key_i,
    output logic             busy_o,
    output logic             round_valid_o,
    input  logic             round_ready_i,
    output logic [IDX_W-1:0] round_idx_o,
    output logic [55:0]      cd_o,
    output logic [47:0]      subkey_o,
    output logic             done_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // PC-2 selection, 1-based from the MSB of C||D
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t           state_q;
    logic             busy_q;
    logic             valid_q;
    logic             done_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [55:0]      cd_q;
    logic [55:0]      cd_d;
    logic             shift_one;
    logic [27:0]      c_half;
    logic [27:0]      d_half;

    // Shift amount is chosen by the index being entered, not the current one
    always_comb begin
        idx_d     = idx_q + IDX_W'(1);
        shift_one = (idx_d == IDX_W'(1)) || (idx_d == IDX_W'(8)) ||
                    (idx_d == IDX_W'(15));
        c_half    = cd_q[55:28];
        d_half    = cd_q[27:0];
        if (shift_one) begin
            cd_d = {c_half[0], c_half[27:1], d_half[0], d_half[27:1]};
        end else begin
            cd_d = {c_half[1:0], c_half[27:2], d_half[1:0], d_half[27:2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            cd_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cd_q    <= key_i;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (round_ready_i) begin
                        if (idx_q == {IDX_W{1'b1}}) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_d;
                            cd_q  <= cd_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    genvar i;
    for (i = 0; i < 48; i++) begin : g_pc2
        assign subkey_o[47-i] = cd_q[56-PC2_TAB[i]];
    end

    assign busy_o        = busy_q;
    assign round_valid_o = valid_q;
    assign round_idx_o   = idx_q;
    assign cd_o          = cd_q;
    assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched_dec.sv
`default_nettype none
// ============================================================================
// Module  : tb_des_key_sched_dec
// Brief   : Self-checking bench for des_key_sched_dec against an encryption-
//           order schedule model replayed backwards.
// Revision: 1.0
// ============================================================================
module tb_des_key_sched_dec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [55:0] key;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [3:0]  idx;
    logic [55:0] cd;
    logic [47:0] subkey;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    des_key_sched_dec #(.IDX_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .key_i         (key),
        .busy_o        (busy),
        .round_valid_o (valid),
        .round_ready_i (ready),
        .round_idx_o   (idx),
        .cd_o          (cd),
        .subkey_o      (subkey),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [27:0] rotl28(logic [27:0] x, int s);
        return (x << s) | (x >> (28 - s));
    endfunction

    // Forward (encryption) schedule CD1..CD16; decrypt round r carries CD(16-r)
    function automatic logic [55:0] model_cd(logic [55:0] k, int r);
        logic [55:0] enc [17];
        logic [27:0] c;
        logic [27:0] d;
        c = k[55:28];
        d = k[27:0];
        enc[0] = k;
        for (int i = 1; i <= 16; i++) begin
            c = rotl28(c, SHIFTS[i-1]);
            d = rotl28(d, SHIFTS[i-1]);
            enc[i] = {c, d};
        end
        return enc[16-r];
    endfunction

    function automatic logic [47:0] pc2(logic [55:0] x);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = x[56-PC2[i]];
        return o;
    endfunction

    // {valid, busy, done, idx, cd, subkey} expected while round r is presented
    function automatic logic [110:0] exp_round(logic [55:0] k, int r);
        logic [55:0] m;
        m = model_cd(k, r);
        return {1'b1, 1'b1, 1'b0, 4'(r), m, pc2(m)};
    endfunction

    function automatic logic [110:0] obs_vec();
        return {valid, busy, done, idx, cd, subkey};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_key(output logic [55:0] k);
        logic [63:0] t;
        t = {$urandom, $urandom};
        k = t[55:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key = '0; ready = 1'b0;
        tick(); tick();
        n_tests++;
        if (obs_vec() !== 111'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", obs_vec());
        end
        #2 rst_n = 1'b1;
        tick();
        n_tests++;
        if (obs_vec() !== 111'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h, required 0", obs_vec());
        end
    endtask

    task automatic test_fips();
        logic [55:0] k;
        k = 56'hF0CCAAF556678F;
        key = k; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            n_tests++;
            if (obs_vec() !== exp_round(k, r)) begin
                n_fail++;
                $display("FAIL fips_round%0d: got %h, required %h", r, obs_vec(), exp_round(k, r));
            end
            if (r == 0) begin
                n_tests++;
                if (subkey !== 48'hCB3D8B0E17F5) begin
                    n_fail++;
                    $display("FAIL fips_k16: got %h, required cb3d8b0e17f5", subkey);
                end
            end
            if (r == 15) begin
                n_tests++;
                if (subkey !== 48'h1B02EFFC7072) begin
                    n_fail++;
                    $display("FAIL fips_k1: got %h, required 1b02effc7072", subkey);
                end
            end
            tick();
        end
        n_tests++;
        if ({done, valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL fips_done_cycle17: got done/valid/busy=%b, required 100", {done, valid, busy});
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_done_pulse: got %b, required 0", done);
        end
    endtask

    task automatic test_rotation_wrap();
        logic [55:0] k;
        k = 56'h80000000000001;
        key = k; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            if (r == 0 || r == 1 || r == 15) begin
                logic [55:0] want;
                want = (r == 0) ? k : (r == 1) ? 56'h40000008000000 : 56'h00000010000002;
                n_tests++;
                if (cd !== want || idx !== 4'(r)) begin
                    n_fail++;
                    $display("FAIL wrap_idx%0d: got idx=%0d cd=%h, required idx=%0d cd=%h", r, idx, cd, r, want);
                end
            end
            tick();
        end
        tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            logic [55:0] k;
            int acc;
            int cyc;
            rand_key(k);
            key = k; start = 1'b1; ready = 1'b0;
            tick();
            start = 1'b0;
            acc = 0; cyc = 0;
            while (acc < 16 && cyc < 200) begin
                ready = ($urandom_range(0, 3) != 0);
                n_tests++;
                if (obs_vec() !== exp_round(k, acc)) begin
                    n_fail++;
                    $display("FAIL random%0d_round%0d: got %h, required %h", t, acc, obs_vec(), exp_round(k, acc));
                end
                if (ready) acc++;
                tick();
                cyc++;
            end
            n_tests++;
            if (acc != 16 || {done, valid, busy} !== 3'b100) begin
                n_fail++;
                $display("FAIL random%0d_done: got accepted=%0d done/valid/busy=%b, required 16 and 100", t, acc, {done, valid, busy});
            end
            ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [55:0] k;
        rand_key(k);
        key = k; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            n_tests++;
            if (obs_vec() !== exp_round(k, r)) begin
                n_fail++;
                $display("FAIL bp_round%0d: got %h, required %h", r, obs_vec(), exp_round(k, r));
            end
            if (r == 3) begin
                ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    n_tests++;
                    if (obs_vec() !== exp_round(k, 3)) begin
                        n_fail++;
                        $display("FAIL bp_hold%0d: got %h, required %h", h, obs_vec(), exp_round(k, 3));
                    end
                end
                ready = 1'b1;
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: got %b, required 1", done);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [55:0] k;
        int dones;
        rand_key(k);
        key = k; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int r = 0; r < 16; r++) begin
            n_tests++;
            if (obs_vec() !== exp_round(k, r)) begin
                n_fail++;
                $display("FAIL busy_start_round%0d: got %h, required %h", r, obs_vec(), exp_round(k, r));
            end
            if (r == 7) begin
                start = 1'b1;
                key = ~k;
            end
            tick();
            start = 1'b0;
        end
        for (int c = 0; c < 6; c++) begin
            if (done) dones++;
            tick();
        end
        n_tests++;
        if (dones != 1 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_done_once: got dones=%0d valid=%b, required 1 and 0", dones, valid);
        end
    endtask

    task automatic test_async_reset();
        logic [55:0] k;
        int dones;
        rand_key(k);
        key = k; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 9; r++) tick();
        n_tests++;
        if (idx !== 4'd9) begin
            n_fail++;
            $display("FAIL areset_reach9: got idx=%0d, required 9", idx);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs_vec() !== 111'd0) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h, required 0", obs_vec());
        end
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) dones++;
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) dones++;
        end
        n_tests++;
        if (dones != 0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_no_done: got dones=%0d valid=%b, required 0 and 0", dones, valid);
        end
        rand_key(k);
        key = k; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            n_tests++;
            if (obs_vec() !== exp_round(k, r)) begin
                n_fail++;
                $display("FAIL areset_restart_round%0d: got %h, required %h", r, obs_vec(), exp_round(k, r));
            end
            tick();
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [55:0] k1;
        logic [55:0] k2;
        rand_key(k1);
        rand_key(k2);
        key = k1; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_done: got %b, required 1", done);
        end
        key = k2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            n_tests++;
            if (obs_vec() !== exp_round(k2, r)) begin
                n_fail++;
                $display("FAIL b2b_second_round%0d: got %h, required %h", r, obs_vec(), exp_round(k2, r));
            end
            tick();
        end
        n_tests++;
        if ({done, valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_second_done: got done/valid/busy=%b, required 100", {done, valid, busy});
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fips();
        test_rotation_wrap();
        test_random();
        test_backpressure();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
